// File: rtl/router_egress_arbiter_if.sv
`default_nettype none
//==============================================================================
// Interface : router_egress_arbiter_if
// Purpose   : Bundles the three router FIFO read ports, the downstream egress
//             byte channel and the arbiter status outputs.
// Modports  : master - arbiter side (consumes FIFO heads, drives egress)
//             slave  - FIFO / downstream side
// Signals   : fifo_empty_0..2, dout_0..2, out_ready     (to arbiter)
//             read_enb_0..2, data_out, data_vld, sop, eop, grant,
//             soft_reset_0..2, abort, busy [, parity_err] (from arbiter)
// Options   : ARB_PARITY_CHK_EN - adds the parity_err signal
// Revision  : 1.0 - initial release
//==============================================================================
interface router_egress_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty_0;
  logic             fifo_empty_1;
  logic             fifo_empty_2;
  logic [WIDTH-1:0] dout_0;
  logic [WIDTH-1:0] dout_1;
  logic [WIDTH-1:0] dout_2;
  logic             out_ready;
  logic             read_enb_0;
  logic             read_enb_1;
  logic             read_enb_2;
  logic [WIDTH-1:0] data_out;
  logic             data_vld;
  logic             sop;
  logic             eop;
  logic [1:0]       grant;
  logic             soft_reset_0;
  logic             soft_reset_1;
  logic             soft_reset_2;
  logic             abort;
  logic             busy;
`ifdef ARB_PARITY_CHK_EN
  logic             parity_err;
`endif

  modport master (
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  dout_0, dout_1, dout_2, out_ready,
    output read_enb_0, read_enb_1, read_enb_2,
    output data_out, data_vld, sop, eop, grant,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output abort, busy
`ifdef ARB_PARITY_CHK_EN
    , output parity_err
`endif
  );

  modport slave (
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output dout_0, dout_1, dout_2, out_ready,
    input  read_enb_0, read_enb_1, read_enb_2,
    input  data_out, data_vld, sop, eop, grant,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  abort, busy
`ifdef ARB_PARITY_CHK_EN
    , input parity_err
`endif
  );
endinterface
`default_nettype wire

// File: rtl/router_egress_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : router_egress_arbiter
// Purpose  : Packet-granular round-robin arbiter draining three router output
//            FIFOs onto one egress byte channel. Packet length comes from the
//            header (len=[7:2]); a starved FIFO is soft-reset after TIMEOUT
//            consecutive starved cycles mid-packet.
// Ports    : clock   - system clock, rising edge
//            resetn  - asynchronous active-low reset
//            bus     - router_egress_arbiter_if.master: FIFO empty/head/pop,
//                      out_ready, registered data_out/data_vld/sop/eop,
//                      grant (2'b11 = none), soft_reset_0..2, abort, busy
// Options  : ARB_PARITY_CHK_EN - adds parity_err, a running-XOR check of the
//            header+payload against the trailing parity byte
// Revision : 1.0 - initial release
//==============================================================================
module router_egress_arbiter #(
  parameter int WIDTH   = 8,   // header layout needs WIDTH >= 8
  parameter int TIMEOUT = 30
) (
  input  wire logic               clock,
  input  wire logic               resetn,
  router_egress_arbiter_if.master bus
);
  localparam int         TO_W       = $clog2(TIMEOUT + 1);
  localparam logic [0:0] c_IDLE     = 1'b0;
  localparam logic [0:0] c_XFER     = 1'b1;
  localparam logic [1:0] c_NO_GRANT = 2'b11;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [1:0]       r_grant;
  logic [1:0]       r_last_grant;
  logic [6:0]       r_byte_cnt;
  logic [5:0]       r_len;
  logic [TO_W-1:0]  r_to_cnt;
  logic [WIDTH-1:0] r_data_out;
  logic             r_data_vld;
  logic             r_sop;
  logic             r_eop;
  logic [2:0]       r_soft_reset;
  logic             r_abort;

  logic [2:0]       w_empty;
  logic             w_g_empty;
  logic [WIDTH-1:0] w_head;
  logic [2:0]       w_grant_oh;
  logic [1:0]       w_c0, w_c1, w_c2;
  logic             w_win_vld;
  logic [1:0]       w_win;
  logic [2:0]       w_read_enb;
  logic             w_pop;
  logic             w_starve;
  logic             w_last;
  logic             w_timeout;
  logic             w_busy;

  function automatic logic [1:0] f_rr_next(input logic [1:0] i_idx);
    return (i_idx == 2'd2) ? 2'd0 : i_idx + 2'd1;
  endfunction

  assign w_empty    = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign w_grant_oh = 3'b001 << r_grant;  // no-grant code shifts out to zero

  // Head byte and empty flag of the currently granted FIFO
  always_comb begin
    w_g_empty = 1'b1;
    w_head    = '0;
    case (r_grant)
      2'd0:    begin w_g_empty = bus.fifo_empty_0; w_head = bus.dout_0; end
      2'd1:    begin w_g_empty = bus.fifo_empty_1; w_head = bus.dout_1; end
      2'd2:    begin w_g_empty = bus.fifo_empty_2; w_head = bus.dout_2; end
      default: begin w_g_empty = 1'b1;             w_head = '0;         end
    endcase
  end

  // Round-robin search starting just after the last granted FIFO
  assign w_c0 = f_rr_next(r_last_grant);
  assign w_c1 = f_rr_next(w_c0);
  assign w_c2 = f_rr_next(w_c1);

  always_comb begin
    w_win_vld = 1'b1;
    w_win     = w_c0;
    if (!w_empty[w_c0])      w_win = w_c0;
    else if (!w_empty[w_c1]) w_win = w_c1;
    else if (!w_empty[w_c2]) w_win = w_c2;
    else begin
      w_win_vld = 1'b0;
      w_win     = c_NO_GRANT;
    end
  end

  // Byte len+1 is the parity byte; byte 0 is excluded because len is only
  // latched from the header on that pop.
  assign w_last    = (r_byte_cnt != 7'd0) && (r_byte_cnt == ({1'b0, r_len} + 7'd1));
  assign w_timeout = w_starve && (r_to_cnt == TO_W'(TIMEOUT - 1));

  // FSM: state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= c_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_win_vld) w_state_nxt = c_XFER;
      c_XFER:  if ((w_pop && w_last) || w_timeout) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // FSM: outputs (pop and starve are mutually exclusive by construction)
  always_comb begin
    w_busy     = (r_state == c_XFER);
    w_read_enb = (w_busy && bus.out_ready && !w_g_empty) ? w_grant_oh : 3'b000;
    w_pop      = |w_read_enb;
    w_starve   = w_busy && bus.out_ready && w_g_empty;
  end

  // Datapath: grant bookkeeping, counters and registered egress
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_grant      <= c_NO_GRANT;
      r_last_grant <= 2'd2;
      r_byte_cnt   <= '0;
      r_len        <= '0;
      r_to_cnt     <= '0;
      r_data_out   <= '0;
      r_data_vld   <= 1'b0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
      r_soft_reset <= 3'b000;
      r_abort      <= 1'b0;
    end else begin
      r_data_vld   <= w_pop;
      r_sop        <= w_pop && (r_byte_cnt == 7'd0);
      r_eop        <= w_pop && w_last;
      r_abort      <= w_timeout;
      r_soft_reset <= w_timeout ? w_grant_oh : 3'b000;
      if (w_pop) r_data_out <= w_head;

      if (r_state == c_IDLE) begin
        r_byte_cnt <= '0;
        r_to_cnt   <= '0;
        if (w_win_vld) begin
          r_grant      <= w_win;
          r_last_grant <= w_win;
        end
      end else if (w_pop) begin
        r_to_cnt <= '0;
        if (r_byte_cnt == 7'd0) r_len <= w_head[7:2];
        if (w_last) begin
          r_grant    <= c_NO_GRANT;
          r_byte_cnt <= '0;
        end else begin
          r_byte_cnt <= r_byte_cnt + 7'd1;
        end
      end else if (w_timeout) begin
        // last_grant keeps the abandoned FIFO so it drops to lowest priority
        r_grant    <= c_NO_GRANT;
        r_byte_cnt <= '0;
        r_to_cnt   <= '0;
      end else if (w_starve) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

`ifdef ARB_PARITY_CHK_EN
  logic [WIDTH-1:0] r_par_acc;
  logic             r_parity_err;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_par_acc    <= '0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_pop && w_last && (r_par_acc != w_head);
      if ((r_state == c_IDLE) || w_timeout) r_par_acc <= '0;
      else if (w_pop)                        r_par_acc <= w_last ? '0 : (r_par_acc ^ w_head);
    end
  end

  assign bus.parity_err = r_parity_err;
`endif

  assign bus.read_enb_0   = w_read_enb[0];
  assign bus.read_enb_1   = w_read_enb[1];
  assign bus.read_enb_2   = w_read_enb[2];
  assign bus.data_out     = r_data_out;
  assign bus.data_vld     = r_data_vld;
  assign bus.sop          = r_sop;
  assign bus.eop          = r_eop;
  assign bus.grant        = r_grant;
  assign bus.soft_reset_0 = r_soft_reset[0];
  assign bus.soft_reset_1 = r_soft_reset[1];
  assign bus.soft_reset_2 = r_soft_reset[2];
  assign bus.abort        = r_abort;
  assign bus.busy         = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_router_egress_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_router_egress_arbiter
// Purpose  : Self-checking bench for router_egress_arbiter. Three FIFOs are
//            modelled as byte queues; a packet-level reference model predicts
//            grants, pops, egress bytes and timeouts every cycle.
// Options  : ARB_PARITY_CHK_EN - also checks parity_err
// Revision : 1.0 - initial release
//==============================================================================
module tb_router_egress_arbiter;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 30;

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  always #5 clock = ~clock;

  router_egress_arbiter_if #(.WIDTH(WIDTH)) ifc ();

  router_egress_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (ifc)
  );

  typedef struct {
    logic       rdy;
    logic       vld;
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [1:0] grant;
    logic       busy;
  } vec_t;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] fq [3][$];
  int         m_cur, m_last, m_pos, m_len, m_starve;
  logic [7:0] m_xor;
  int         prev_gnt;
  int         gnt_log [$];
  logic [7:0] out_log [$];
  logic [7:0] sent_log [$];
  int         perr_log [$];
  int         abort_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    ifc.fifo_empty_0 = (fq[0].size() == 0);
    ifc.fifo_empty_1 = (fq[1].size() == 0);
    ifc.fifo_empty_2 = (fq[2].size() == 0);
    ifc.dout_0 = (fq[0].size() != 0) ? fq[0][0] : 8'h00;
    ifc.dout_1 = (fq[1].size() != 0) ? fq[1][0] : 8'h00;
    ifc.dout_2 = (fq[2].size() != 0) ? fq[2][0] : 8'h00;
  endtask

  task automatic push_pkt(input int x, input int len, input logic [1:0] addr, input bit bad);
    logic [7:0] b, par;
    b = {6'(len), addr};
    par = b;
    fq[x].push_back(b);
    sent_log.push_back(b);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      par ^= b;
      fq[x].push_back(b);
      sent_log.push_back(b);
    end
    if (bad) par = ~par;
    fq[x].push_back(par);
    sent_log.push_back(par);
    drive_fifo();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    chk("rst_grant", 32'(ifc.grant), 32'd3);
    chk("rst_data_vld", 32'(ifc.data_vld), 32'd0);
    chk("rst_data_out", 32'(ifc.data_out), 32'd0);
    chk("rst_sop_eop", 32'({ifc.sop, ifc.eop}), 32'd0);
    chk("rst_abort_busy", 32'({ifc.abort, ifc.busy}), 32'd0);
    chk("rst_soft_reset", 32'({ifc.soft_reset_2, ifc.soft_reset_1, ifc.soft_reset_0}), 32'd0);
    chk("rst_read_enb", 32'({ifc.read_enb_2, ifc.read_enb_1, ifc.read_enb_0}), 32'd0);
`ifdef ARB_PARITY_CHK_EN
    chk("rst_parity_err", 32'(ifc.parity_err), 32'd0);
`endif
    ifc.out_ready = 1'b0;
    for (int x = 0; x < 3; x++) fq[x].delete();
    drive_fifo();
    m_cur = -1; m_last = 2; m_pos = 0; m_len = 0; m_starve = 0; m_xor = '0;
    prev_gnt = 3;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // One clock: predict at the falling edge, compare after the rising edge.
  task automatic cyc();
    logic [2:0] re, exp_re, exp_sr;
    logic [7:0] pop_byte;
    bit         do_pop, do_abort, do_arb, exp_sop, exp_eop, exp_perr;
    int         nxt, c;
    drive_fifo();
    @(negedge clock);
    re = {ifc.read_enb_2, ifc.read_enb_1, ifc.read_enb_0};
    exp_re = 3'b000; pop_byte = '0; nxt = 3;
    do_pop = 0; do_abort = 0; do_arb = 0;
    if (m_cur >= 0) begin
      if (ifc.out_ready && fq[m_cur].size() != 0) begin
        exp_re[m_cur] = 1'b1;
        do_pop = 1;
        pop_byte = fq[m_cur][0];
      end else if (ifc.out_ready) begin
        m_starve++;
        if (m_starve == TIMEOUT) do_abort = 1;
      end
    end else begin
      for (int k = 1; k <= 3; k++) begin
        c = (m_last + k) % 3;
        if (nxt == 3 && fq[c].size() != 0) nxt = c;
      end
      do_arb = (nxt != 3);
    end
    chk("read_enb", 32'(re), 32'(exp_re));

    @(posedge clock);
    #1;
    for (int x = 0; x < 3; x++)
      if (re[x] && fq[x].size() != 0) void'(fq[x].pop_front());

    exp_sop = 0; exp_eop = 0; exp_perr = 0; exp_sr = 3'b000;
    if (do_pop) begin
      exp_sop = (m_pos == 0);
      if (m_pos == 0) begin
        m_len = int'(pop_byte[7:2]);
        m_xor = '0;
      end
      exp_eop = (m_pos == m_len + 1);
      if (exp_eop) exp_perr = (m_xor != pop_byte);
      else         m_xor ^= pop_byte;
      m_pos++;
      m_starve = 0;
      if (exp_eop) begin m_cur = -1; m_pos = 0; end
    end
    if (do_abort) begin
      exp_sr[m_cur] = 1'b1;
      m_cur = -1; m_pos = 0; m_starve = 0;
    end
    if (do_arb) begin
      m_cur = nxt; m_last = nxt; m_pos = 0; m_starve = 0;
    end

    chk("data_vld", 32'(ifc.data_vld), 32'(do_pop));
    if (do_pop) chk("data_out", 32'(ifc.data_out), 32'(pop_byte));
    chk("sop", 32'(ifc.sop), 32'(exp_sop));
    chk("eop", 32'(ifc.eop), 32'(exp_eop));
    chk("grant", 32'(ifc.grant), (m_cur < 0) ? 32'd3 : 32'(m_cur));
    chk("busy", 32'(ifc.busy), 32'(m_cur >= 0));
    chk("soft_reset", 32'({ifc.soft_reset_2, ifc.soft_reset_1, ifc.soft_reset_0}), 32'(exp_sr));
    chk("abort", 32'(ifc.abort), 32'(do_abort));
`ifdef ARB_PARITY_CHK_EN
    chk("parity_err", 32'(ifc.parity_err), 32'(exp_perr));
    if (ifc.eop) perr_log.push_back(int'(ifc.parity_err));
`endif

    if (ifc.data_vld) out_log.push_back(ifc.data_out);
    if (prev_gnt == 3 && ifc.grant != 2'b11) gnt_log.push_back(int'(ifc.grant));
    prev_gnt = int'(ifc.grant);
    if (ifc.abort || ifc.soft_reset_0 || ifc.soft_reset_1 || ifc.soft_reset_2) abort_seen++;
    if (ifc.soft_reset_0) fq[0].delete();
    if (ifc.soft_reset_1) fq[1].delete();
    if (ifc.soft_reset_2) fq[2].delete();
    drive_fifo();
  endtask

  task automatic drain(input int max, input string name);
    int n;
    n = 0;
    ifc.out_ready = 1'b1;
    while ((fq[0].size() + fq[1].size() + fq[2].size() != 0 || m_cur >= 0 ||
            ifc.grant != 2'b11) && n < max) begin
      cyc();
      n++;
    end
    chk({name, "_drain_in_budget"}, 32'(n < max), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [7];
    logic [7:0] pkt [5];
    bit         refilled;
    int         k, x;
    int         exp_rr [5];

    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 8'h0C, 1'b1, 1'b0, 2'd0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 8'h0C, 1'b0, 1'b1, 2'd3, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 1'b0};
    pkt = '{8'h0C, 8'h11, 8'h22, 8'h33, 8'h0C};
    exp_rr = '{0, 1, 2, 0, 2};

    ifc.out_ready = 1'b0;
    drive_fifo();
    #2;

    // Single-FIFO packet, table driven
    do_reset();
    for (int i = 0; i < 5; i++) fq[0].push_back(pkt[i]);
    for (int i = 0; i < 7; i++) begin
      ifc.out_ready = tbl[i].rdy;
      cyc();
      chk($sformatf("tbl[%0d].vld", i), 32'(ifc.data_vld), 32'(tbl[i].vld));
      if (tbl[i].vld) chk($sformatf("tbl[%0d].data", i), 32'(ifc.data_out), 32'(tbl[i].data));
      chk($sformatf("tbl[%0d].sop", i), 32'(ifc.sop), 32'(tbl[i].sop));
      chk($sformatf("tbl[%0d].eop", i), 32'(ifc.eop), 32'(tbl[i].eop));
      chk($sformatf("tbl[%0d].grant", i), 32'(ifc.grant), 32'(tbl[i].grant));
      chk($sformatf("tbl[%0d].busy", i), 32'(ifc.busy), 32'(tbl[i].busy));
    end

    // Round robin with refill once FIFO1 is granted
    do_reset();
    gnt_log.delete();
    push_pkt(0, 1, 2'd0, 1'b0);
    push_pkt(1, 1, 2'd1, 1'b0);
    push_pkt(2, 1, 2'd2, 1'b0);
    ifc.out_ready = 1'b1;
    refilled = 0;
    k = 0;
    while (gnt_log.size() < 5 && k < 200) begin
      cyc();
      k++;
      if (!refilled && ifc.grant == 2'd1) begin
        push_pkt(0, 1, 2'd0, 1'b0);
        push_pkt(2, 1, 2'd2, 1'b0);
        refilled = 1;
      end
    end
    chk("rr_grant_count", 32'(gnt_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++)
      chk($sformatf("rr_order[%0d]", i), 32'(gnt_log[i]), 32'(exp_rr[i]));
    drain(100, "rr");

    // Backpressure including a 40-cycle stall
    do_reset();
    sent_log.delete(); out_log.delete(); abort_seen = 0;
    push_pkt(0, 4, 2'd0, 1'b0);
    k = 0;
    while (!(out_log.size() == 6 && ifc.grant == 2'b11) && k < 300) begin
      ifc.out_ready = (k >= 10 && k < 50) ? 1'b0 : (k % 3 == 0);
      cyc();
      k++;
    end
    chk("bp_byte_count", 32'(out_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < out_log.size(); i++)
      chk($sformatf("bp_byte[%0d]", i), 32'(out_log[i]), 32'(sent_log[i]));
    chk("bp_no_soft_reset", 32'(abort_seen), 32'd0);

    // Timeout on a starved FIFO1
    do_reset();
    out_log.delete();
    fq[1].push_back(8'h15); fq[1].push_back(8'hA1); fq[1].push_back(8'hA2);
    ifc.out_ready = 1'b1;
    k = 0;
    while (out_log.size() < 3 && k < 20) begin cyc(); k++; end
    chk("to_head_bytes", 32'(out_log.size()), 32'd3);
    k = 0;
    do begin cyc(); k++; end while (!ifc.abort && k < 80);
    chk("to_starved_cycles", 32'(k), 32'(TIMEOUT));
    chk("to_soft_reset", 32'({ifc.soft_reset_2, ifc.soft_reset_1, ifc.soft_reset_0}), 32'b010);
    chk("to_no_eop", 32'(ifc.eop), 32'd0);
    cyc();
    chk("to_abort_pulse", 32'(ifc.abort), 32'd0);
    chk("to_idle_grant", 32'(ifc.grant), 32'd3);
    chk("to_idle_busy", 32'(ifc.busy), 32'd0);

    // Reset during byte 2 of a len-10 packet
    do_reset();
    out_log.delete();
    push_pkt(0, 10, 2'd0, 1'b0);
    ifc.out_ready = 1'b1;
    k = 0;
    while (out_log.size() < 3 && k < 20) begin cyc(); k++; end
    chk("mid_bytes_before_reset", 32'(out_log.size()), 32'd3);
    #2;
    do_reset();
    gnt_log.delete();
    push_pkt(1, 1, 2'd1, 1'b0);
    push_pkt(0, 1, 2'd0, 1'b0);
    drain(100, "mid");
    chk("mid_first_grant", (gnt_log.size() != 0) ? 32'(gnt_log[0]) : 32'hFFFF, 32'd0);

`ifdef ARB_PARITY_CHK_EN
    // Good then corrupted parity byte
    do_reset();
    perr_log.delete();
    push_pkt(0, 3, 2'd2, 1'b0);
    push_pkt(0, 3, 2'd2, 1'b1);
    drain(100, "par");
    chk("par_eop_count", 32'(perr_log.size()), 32'd2);
    if (perr_log.size() == 2) begin
      chk("par_good", 32'(perr_log[0]), 32'd0);
      chk("par_bad", 32'(perr_log[1]), 32'd1);
    end
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        x = $urandom_range(0, 2);
        if (fq[x].size() < 60)
          push_pkt(x, $urandom_range(0, 20), 2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
      end
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drain(3000, "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
